// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM sample-read path: address/data widths and
// the layout of a returned chunk (address in the top bits, data below).
package dram_pkg;

  localparam int ADDR_WIDTH       = 24;
  localparam int CHUNK_DATA_WIDTH = 128;
  localparam int CHUNK_WIDTH      = ADDR_WIDTH + CHUNK_DATA_WIDTH;  // 152

  // Field positions inside a returned chunk.
  localparam int CHUNK_ADDR_MSB = CHUNK_WIDTH - 1;       // 151
  localparam int CHUNK_ADDR_LSB = CHUNK_DATA_WIDTH;      // 128
  localparam int CHUNK_DATA_MSB = CHUNK_DATA_WIDTH - 1;  // 127
  localparam int CHUNK_DATA_LSB = 0;

  typedef logic [ADDR_WIDTH-1:0]       chunk_addr_t;
  typedef logic [CHUNK_DATA_WIDTH-1:0] chunk_data_t;
  typedef logic [CHUNK_WIDTH-1:0]      chunk_t;

  function automatic chunk_addr_t chunk_addr(input chunk_t c);
    return c[CHUNK_ADDR_MSB:CHUNK_ADDR_LSB];
  endfunction

  function automatic chunk_data_t chunk_data(input chunk_t c);
    return c[CHUNK_DATA_MSB:CHUNK_DATA_LSB];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector starting
// one past the previous winner and wraps modulo N.
module rr_arbiter #(
  parameter int N    = 8,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last_idx,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            any_grant
);

  // First requester found after last_idx (wrapping) wins.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_idx) + k) % N;
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDXW'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_read_scheduler.sv
// Turns per-instrument trigger pulses into a round-robin stream of chunk read
// addresses. Each instrument walks its region [addr_starts[i], addr_starts[i+1])
// and is limited to MAX_OUTSTANDING chunks in flight by a credit counter.
//
// Command handshake: cmd_axis_tdata is transferred on a clock edge where
// cmd_axis_tvalid && cmd_axis_tready. Once tvalid is high, tvalid and tdata
// hold until that transfer; the output register reloads only when it is empty
// or being drained in the same cycle.
module dram_read_scheduler
  import dram_pkg::*;
#(
  parameter int INSTRUMENT_COUNT = 8,
  parameter int MAX_OUTSTANDING  = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [ADDR_WIDTH*(INSTRUMENT_COUNT+1)-1:0]   addr_starts,
  input  logic [INSTRUMENT_COUNT-1:0]                  trigger,
  input  logic [INSTRUMENT_COUNT-1:0]                  chunk_consumed,
  output logic                                         cmd_axis_tvalid,
  input  logic                                         cmd_axis_tready,
  output logic [ADDR_WIDTH-1:0]                        cmd_axis_tdata,
  output logic [INSTRUMENT_COUNT-1:0]                  active
);

  localparam int N    = INSTRUMENT_COUNT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0]            MAX_USED = 4'(MAX_OUTSTANDING);
  localparam logic [3:0]            ONE_USED = 4'd1;
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] ptr  [N];
  logic [3:0]            used [N];
  logic [IDXW-1:0]       rr;

  logic [N-1:0]    eligible;
  logic [N-1:0]    grant_oh;
  logic [IDXW-1:0] grant_idx;
  logic            any_grant;
  logic            load;
  logic            do_issue;
  logic [N-1:0]    issue;
  logic [N-1:0]    trig_ok;
  logic [N-1:0]    last_chunk;
  logic [N-1:0]    credit_ret;

  // An instrument may request while it has addresses left and credits free.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = active[i] && (used[i] < MAX_USED);
    end
  end

  rr_arbiter #(
    .N    (N),
    .IDXW (IDXW)
  ) u_arb (
    .req       (eligible),
    .last_idx  (rr),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Per-instrument events for this cycle: issue, valid restart, region end, credit return.
  always_comb begin
    load       = !cmd_axis_tvalid || cmd_axis_tready;
    do_issue   = load && any_grant;
    issue      = '0;
    trig_ok    = '0;
    last_chunk = '0;
    credit_ret = '0;
    for (int i = 0; i < N; i++) begin
      issue[i]      = do_issue && grant_oh[i];
      trig_ok[i]    = trigger[i] &&
                      (addr_starts[i*ADDR_WIDTH +: ADDR_WIDTH] <
                       addr_starts[(i+1)*ADDR_WIDTH +: ADDR_WIDTH]);
      last_chunk[i] = (ptr[i] + ONE_ADDR) == addr_starts[(i+1)*ADDR_WIDTH +: ADDR_WIDTH];
      credit_ret[i] = chunk_consumed[i] && (used[i] != 4'd0);
    end
  end

  // Playback pointers, activity flags and credit counters; restart beats issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
      for (int i = 0; i < N; i++) begin
        ptr[i]  <= '0;
        used[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (trig_ok[i]) begin
          ptr[i]    <= addr_starts[i*ADDR_WIDTH +: ADDR_WIDTH];
          active[i] <= 1'b1;
        end else if (issue[i]) begin
          ptr[i] <= ptr[i] + ONE_ADDR;
          if (last_chunk[i]) active[i] <= 1'b0;
        end
        if (issue[i] && !credit_ret[i]) begin
          used[i] <= used[i] + ONE_USED;
        end else if (!issue[i] && credit_ret[i]) begin
          used[i] <= used[i] - ONE_USED;
        end
      end
    end
  end

  // Command output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_axis_tvalid <= 1'b0;
      cmd_axis_tdata  <= '0;
      rr              <= IDXW'(N - 1);
    end else if (do_issue) begin
      cmd_axis_tvalid <= 1'b1;
      cmd_axis_tdata  <= ptr[grant_idx];
      rr              <= grant_idx;
    end else if (load) begin
      cmd_axis_tvalid <= 1'b0;
    end
  end

  // A credit returned with nothing outstanding means the read path is out of step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        assert (!(chunk_consumed[i] && used[i] == 4'd0))
          else $error("dram_read_scheduler: credit return on instrument %0d with none outstanding", i);
      end
    end
  end

endmodule
